// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and frame-length constants,
// used by both the transmitter and the matching receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high and
// pulses tick on the wrap cycle; held at zero while run is low.
module uart_baud_cnt #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_baud_cnt: CLKS_PER_BIT must be at least 2");
      end
   endgenerate

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      tick = run && (cnt == LAST);
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one
// stop bit; ready/valid byte input and a registered, glitch-free txd line.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       txd,
   output logic       busy
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   uart_state_t state;
   logic [7:0]  shreg;
   logic [2:0]  bit_idx;
   logic        tick;
   logic        run;

   always_comb begin
      run = (state != IDLE);
   end

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk (clk),
      .rst (rst),
      .run (run),
      .tick(tick)
   );

   // txd always carries the level of the bit being entered, so it is set on
   // the same edge as the state change rather than decoded from the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         tx_ready <= 1'b1;
         busy     <= 1'b0;
         shreg    <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  shreg    <= tx_data;
                  bit_idx  <= '0;
                  txd      <= 1'b0;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (tick) begin
                  txd   <= shreg[0];
                  state <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_IDX) begin
                     if (PARITY_EN) begin
                        txd   <= (^shreg) ^ PARITY_ODD;
                        state <= PARITY;
                     end else begin
                        txd   <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[bit_idx + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  txd   <= 1'b1;
                  state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               txd      <= 1'b1;
               tx_ready <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (4 clk/bit no parity,
// 4 clk/bit even parity, 2 clk/bit odd parity) driven from a vector table,
// hand sequences and random bytes checked against a frame-level model.
module tb_uart_tx;

   localparam int NB   [3] = '{4, 4, 2};
   localparam bit PEN  [3] = '{1'b0, 1'b1, 1'b1};
   localparam bit PODD [3] = '{1'b0, 1'b0, 1'b1};

   logic       clk;
   logic       rst;
   logic [2:0] tx_valid;
   logic [7:0] tx_data [3];
   logic [2:0] tx_ready;
   logic [2:0] txd;
   logic [2:0] busy;

   int checks   = 0;
   int failures = 0;

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut0 (
      .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0]));

   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1]));

   uart_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
      .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          dut;
      logic [7:0]  data;
      bit          keep;
      int          glitch;
      logic [10:0] bits;
      int          nbits;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input int k, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
      end
   endtask

   // Frame as a list of line levels: start, data LSB first, parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b, input bit par,
                                               input bit odd);
      logic [10:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
      if (par) f[9] = (^b) ^ odd;
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_check(input int k, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         step();
         chk("idle_txd", k, {7'd0, txd[k]}, 8'd1);
         chk("idle_ready", k, {7'd0, tx_ready[k]}, 8'd1);
      end
   endtask

   // Entered and left #1 after an edge with the instance idle.
   task automatic send_frame(input int k, input logic [7:0] b, input logic [10:0] bits,
                             input int nbits, input bit keep, input int glitch);
      int         n;
      int         bi;
      logic [7:0] rx;
      n  = NB[k];
      rx = '0;
      chk("pre_ready", k, {7'd0, tx_ready[k]}, 8'd1);
      chk("pre_txd", k, {7'd0, txd[k]}, 8'd1);
      tx_data[k]  = b;
      tx_valid[k] = 1'b1;
      step();
      if (keep) begin
         tx_data[k] = 8'($urandom);
      end else begin
         tx_valid[k] = 1'b0;
         tx_data[k]  = 'x;
      end
      for (int s = 0; s < nbits * n; s++) begin
         if (s > 0) step();
         bi = s / n;
         chk("frame_txd", k, {7'd0, txd[k]}, {7'd0, bits[bi]});
         chk("frame_ready", k, {7'd0, tx_ready[k]}, 8'd0);
         chk("frame_busy", k, {7'd0, busy[k]}, 8'd1);
         if ((s % n) == (n / 2) && bi >= 1 && bi <= 8) rx[bi-1] = txd[k];
         if (glitch >= 0 && s == glitch) begin
            tx_valid[k] = 1'b1;
            tx_data[k]  = ~b;
         end
         if (glitch >= 0 && s == glitch + 1) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 'x;
         end
      end
      chk("rx_byte", k, rx, b);
      step();
      chk("gap_txd", k, {7'd0, txd[k]}, 8'd1);
      chk("gap_ready", k, {7'd0, tx_ready[k]}, 8'd1);
      chk("gap_busy", k, {7'd0, busy[k]}, 8'd0);
   endtask

   initial begin
      logic [7:0] b;
      bit         keep;
      int         g;
      int         nb;

      vecs[0] = '{0, 8'hA5, 1'b0, -1, 11'h34A, 10};
      vecs[1] = '{1, 8'hA5, 1'b0, -1, 11'h54A, 11};
      vecs[2] = '{1, 8'h01, 1'b0, -1, 11'h602, 11};
      vecs[3] = '{0, 8'h00, 1'b1, -1, 11'h200, 10};
      vecs[4] = '{0, 8'hFF, 1'b0, -1, 11'h3FE, 10};
      vecs[5] = '{0, 8'h5A, 1'b0, 14, 11'h2B4, 10};
      vecs[6] = '{2, 8'h55, 1'b1, -1, 11'h6AA, 11};
      vecs[7] = '{2, 8'h55, 1'b1, -1, 11'h6AA, 11};
      vecs[8] = '{2, 8'h55, 1'b0, -1, 11'h6AA, 11};

      rst      = 1'b1;
      tx_valid = '0;
      for (int k = 0; k < 3; k++) tx_data[k] = 'x;
      repeat (3) step();
      for (int k = 0; k < 3; k++) begin
         chk("rst_txd", k, {7'd0, txd[k]}, 8'd1);
         chk("rst_ready", k, {7'd0, tx_ready[k]}, 8'd1);
         chk("rst_busy", k, {7'd0, busy[k]}, 8'd0);
      end
      rst = 1'b0;

      for (int v = 0; v < 9; v++) begin
         send_frame(vecs[v].dut, vecs[v].data, vecs[v].bits, vecs[v].nbits,
                    vecs[v].keep, vecs[v].glitch);
         if (vecs[v].glitch >= 0) idle_check(vecs[v].dut, 2 * NB[vecs[v].dut]);
      end

      // Abort a frame during data bit 3, then send immediately after release.
      tx_data[0]  = 8'hC3;
      tx_valid[0] = 1'b1;
      step();
      tx_valid[0] = 1'b0;
      tx_data[0]  = 'x;
      for (int s = 0; s < 4 * NB[0] + 1; s++) step();
      chk("abort_busy_before", 0, {7'd0, busy[0]}, 8'd1);
      rst = 1'b1;
      #1;
      chk("abort_txd", 0, {7'd0, txd[0]}, 8'd1);
      chk("abort_ready", 0, {7'd0, tx_ready[0]}, 8'd1);
      chk("abort_busy", 0, {7'd0, busy[0]}, 8'd0);
      step();
      rst = 1'b0;
      send_frame(0, 8'h3C, 11'h278, 10, 1'b0, -1);
      idle_check(0, 2 * NB[0]);

      for (int k = 0; k < 3; k++) begin
         nb = PEN[k] ? 11 : 10;
         for (int r = 0; r < 6; r++) begin
            b    = 8'($urandom);
            keep = (r < 5) ? 1'($urandom % 2) : 1'b0;
            g    = (!keep && ($urandom % 3) == 0) ? int'($urandom_range(nb * NB[k] - 3, 1)) : -1;
            send_frame(k, b, model_frame(b, PEN[k], PODD[k]), nb, keep, g);
            if (!keep) idle_check(k, (g >= 0) ? 2 * NB[k] : int'($urandom_range(3, 0)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
